// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction-memory loader. It takes a byte stream made of a
// 16-bit big-endian word count followed by big-endian 32-bit instruction
// words. Each assembled word is written to the next word-aligned address,
// starting at BASE_ADDR. core_hold keeps the core stalled until the image is
// complete.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a trailing checksum byte must follow the image. It must
//   equal the XOR of all payload bytes. A mismatch ends the load in ERR.
//   When undefined, the stream ends after the last word.
//
// Handshake: a byte transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready depends only on the current state, so it
// never depends combinationally on in_valid. A byte offered while in_ready
// is 0 stays with the producer.
//
// Ports:
//   clk        in   1   clock
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   begins a load; honoured in IDLE, DONE or ERR only
//   in_data    in   8   stream byte
//   in_valid   in   1   in_data is valid
//   in_ready   out  1   loader accepts a byte this cycle
//   mem_we     out  1   instruction-memory write strobe (one cycle per word)
//   mem_addr   out  32  byte address of the write
//   mem_wdata  out  32  instruction word
//   core_hold  out  1   core stalled (1 in every state except DONE)
//   done       out  1   image loaded successfully (level)
//   error      out  1   load aborted (level)
//
// The FSM state is held in the internal signal 'state' for debug and
// checker binding.
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        core_hold,
   output logic        done,
   output logic        error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_WORD   = 3'd3,
      S_WRITE  = 3'd4,
      S_CHK    = 3'd5,
      S_DONE   = 3'd6,
      S_ERR    = 3'd7
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_WORD   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd6,
      S_ERR    = 3'd7
   } state_t;
`endif

   state_t      state;
   state_t      next_state;

   logic [7:0]  len_hi;     // count[15:8], captured in LEN_HI
   logic [15:0] count;      // words in this image
   logic [15:0] widx;       // index of the word being assembled/written
   logic [1:0]  byte_pos;   // byte position within the current word
   logic [23:0] word_sr;    // first three bytes of the current word
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum;       // running XOR of payload bytes
`endif

   logic        xfer;
   logic        begin_load;
   logic [15:0] len_val;
   logic        last_word;

   assign xfer       = in_valid && in_ready;
   assign begin_load = start && ((state == S_IDLE) || (state == S_DONE) ||
                                 (state == S_ERR));
   assign len_val    = {len_hi, in_data};
   assign last_word  = (widx == (count - 16'd1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) next_state = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (xfer) next_state = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (xfer) begin
               if (len_val == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  next_state = S_CHK;
`else
                  next_state = S_DONE;
`endif
               end else if ({16'd0, len_val} > MAX_WORDS) begin
                  next_state = S_ERR;
               end else begin
                  next_state = S_WORD;
               end
            end
         end
         S_WORD: begin
            if (xfer && (byte_pos == 2'd3)) next_state = S_WRITE;
         end
         S_WRITE: begin
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               next_state = S_CHK;
`else
               next_state = S_DONE;
`endif
            end else begin
               next_state = S_WORD;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (xfer) next_state = (in_data == csum) ? S_DONE : S_ERR;
         end
`endif
         default: next_state = S_IDLE;
      endcase
   end

   // Status outputs are decoded from the registered state only.
   always_comb begin
      in_ready  = 1'b0;
      core_hold = 1'b1;
      done      = 1'b0;
      error     = 1'b0;
      case (state)
         S_LEN_HI, S_LEN_LO, S_WORD: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK:                      in_ready = 1'b1;
`endif
         S_DONE: begin
            core_hold = 1'b0;
            done      = 1'b1;
         end
         S_ERR:                      error = 1'b1;
         default: ;
      endcase
   end

   // Datapath: the write strobe, address and data are registered on the 4th
   // byte of a word so all three are valid together during the WRITE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we    <= 1'b0;
         mem_addr  <= BASE_ADDR;
         mem_wdata <= 32'd0;
         len_hi    <= 8'd0;
         count     <= 16'd0;
         widx      <= 16'd0;
         byte_pos  <= 2'd0;
         word_sr   <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum      <= 8'd0;
`endif
      end else begin
         mem_we <= 1'b0;
         if (begin_load) begin
            widx     <= 16'd0;
            byte_pos <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= 8'd0;
`endif
         end
         case (state)
            S_LEN_HI: begin
               if (xfer) len_hi <= in_data;
            end
            S_LEN_LO: begin
               if (xfer) count <= len_val;
            end
            S_WORD: begin
               if (xfer) begin
                  word_sr  <= {word_sr[15:0], in_data};
                  byte_pos <= byte_pos + 2'd1;   // wraps to 0 after byte 3
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum     <= csum ^ in_data;
`endif
                  if (byte_pos == 2'd3) begin
                     mem_we    <= 1'b1;
                     mem_wdata <= {word_sr, in_data};
                     mem_addr  <= BASE_ADDR + {14'd0, widx, 2'b00};
                  end
               end
            end
            S_WRITE: begin
               widx <= widx + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
